change_dispenser: RTL
=====================

# change_dispenser

Downstream stage of the change calculator. It accepts the per-denomination coin counts as one load and drives the five coin-ejector solenoids. Coins are dispensed one at a time, largest denomination first, with a fixed pulse width and inter-coin gap. It reports a running cents total and a one-cycle `done` when the last coin has gone.

## Interface

Parameters:
- `PULSE_CYCLES`, default 4: ejector on-time per coin, in cycles (≥1).
- `GAP_CYCLES`, default 2: all-ejectors-off time after each coin, in cycles (≥1).
- `SENSE_TIMEOUT`, default 16: maximum wait for the coin sensor, in cycles. Used only with the sense feature.

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `reset`, in, 1: synchronous, active-low.
- `load`, in, 1: capture the count inputs; honoured only while `ready`=1.
- `dollars`, `halves`, `quarters`, `dimes`, `nickels`, in, 4 each: coin counts, 0–15.
- `abort`, in, 1: cancel dispensing.
- `coin_sensed`, in, 1: coin-drop sensor pulse. Used only with the sense feature.
- `ready`, out, 1: high in IDLE.
- `busy`, out, 1: high in every state except IDLE.
- `eject`, out, 5: one-hot solenoid drive; [4]=dollar, [3]=half, [2]=quarter, [1]=dime, [0]=nickel.
- `dispensed_cents`, out, 12: cents dispensed since the last accepted load. Maximum 15×190=2850.
- `done`, out, 1: one-cycle pulse on completion.
- `fault`, out, 1: sensor timeout. Held until reset or abort.

## Operation

- **Reset** (`reset`=0 at an edge):
  - State IDLE; all counts 0.
  - `eject`=0, `dispensed_cents`=0, `done`=0, `fault`=0, `busy`=0, `ready`=1.
  - Reset applies from any state, including mid-pulse; `eject` drops on that edge.
- **IDLE:** `load`=1 copies the five counts into internal down-counters, clears `dispensed_cents`, and moves to SELECT. `load` is ignored outside IDLE.
- **SELECT (1 cycle):** pick the highest nonzero denomination in dollar→nickel order and go to PULSE. If all counts are zero, go to DONE.
- **PULSE:** `eject` bit of the selected denomination is high for `PULSE_CYCLES` cycles. Without the sense feature, on the last pulse cycle:
  - the count is decremented;
  - `dispensed_cents` increases by the coin value (100/50/25/10/5);
  - next state is GAP.
- **GAP:** `eject`=0 for `GAP_CYCLES` cycles, then SELECT.
- **DONE (1 cycle):** `done`=1, then IDLE.
- **abort:**
  - `abort`=1 in any busy state: IDLE on the next edge, `eject`=0, remaining counts discarded, no `done` pulse.
  - `dispensed_cents` holds its value and `fault` clears.
  - If `abort` and `load` are both high in IDLE, abort has no effect and the load is accepted.
- **Width:** `dispensed_cents` is 12-bit unsigned and never wraps within legal counts.

## Timing

- Load sampled at edge 0 → SELECT in cycle 1 → first `eject` high in cycles 2 … 1+P.
- Cost per coin: 1+P+G cycles (SELECT+PULSE+GAP), where P=`PULSE_CYCLES` and G=`GAP_CYCLES`.
- For N coins in open-loop mode, `done` is high in cycle 2+N·(1+P+G); `ready` returns the cycle after.
- For an all-zero load, `done` is in cycle 2.
- `eject` is registered, never has more than one bit set, and is never high in SELECT, GAP, DONE, IDLE or FAULT.

## Configuration

Macro: `CHANGE_DISPENSER_SENSE_EN`.

Defined:
- After PULSE, enter WAIT_SENSE with `eject`=0, for up to `SENSE_TIMEOUT` cycles.
- `coin_sensed`=1 in WAIT_SENSE decrements the count, adds the coin value to `dispensed_cents`, and moves to GAP. The PULSE-end update is then skipped.
- Timeout → FAULT: `fault`=1, `busy`=1, `ready`=0. Leave only via reset or `abort`.
- `coin_sensed` is ignored outside WAIT_SENSE.

Not defined:
- Open-loop operation as described in Operation.
- No WAIT_SENSE or FAULT states; `coin_sensed` unused; `fault` tied to 0.

## Test plan

All scenarios use P=4, G=2.

- **Reset mid-pulse:** load dollars=3; assert `reset`=0 in cycle 3 → `eject`=0, `ready`=1, `dispensed_cents`=0 on the next cycle.
- **Two coins:** load dollars=1, quarters=1 at edge 0 →
  - `eject`=10000 in cycles 2–5;
  - `eject`=00100 in cycles 9–12;
  - `done` in cycle 16;
  - `dispensed_cents`=125.
- **Zero load:** load all counts 0 → `done` in cycle 2, `eject` never set, `dispensed_cents`=0.
- **Maximum load:** all counts 15 → 75 pulses in dollar→nickel order, `dispensed_cents`=2850, `done` in cycle 527.
- **Abort and busy load:**
  - load dimes=4; assert `abort` in cycle 10 → IDLE in cycle 11, no `done`, `dispensed_cents`=10.
  - A `load` asserted in cycle 5 is ignored.
- **Sense feature** (`CHANGE_DISPENSER_SENSE_EN`): load nickels=2; pulse `coin_sensed` for coin 1 only →
  - `dispensed_cents`=5;
  - `fault`=1 sixteen cycles after coin 2's pulse ends;
  - `abort` clears `fault` and returns to IDLE.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: ejects loaded coins one at a time, largest first, with a running cents total.
// Define CHANGE_DISPENSER_SENSE_EN to confirm each coin on coin_sensed, with a timeout fault.
module change_dispenser #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES = 2,
  parameter int SENSE_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [3:0]  dollars,
  input  logic [3:0]  halves,
  input  logic [3:0]  quarters,
  input  logic [3:0]  dimes,
  input  logic [3:0]  nickels,
  input  logic        abort,
  input  logic        coin_sensed,
  output logic        ready,
  output logic        busy,
  output logic [4:0]  eject,
  output logic [11:0] dispensed_cents,
  output logic        done,
  output logic        fault
);
  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE, WAIT_SENSE, FAULT} state_t;
  state_t state, state_d;
  logic [4:0][3:0] cnt, cnt_d;
  logic [2:0] sel, sel_d, pick;
  logic [15:0] tmr, tmr_d;
  logic [11:0] cents_d, val;
  logic [4:0] eject_d;
  always_comb begin
    pick = 3'd0;
    for (int i = 0; i < 5; i++)
      if (cnt[i] != 4'd0) pick = 3'(i);
  end
  always_comb
    val = sel == 3'd4 ? 12'd100 : sel == 3'd3 ? 12'd50 : sel == 3'd2 ? 12'd25 : sel == 3'd1 ? 12'd10 : 12'd5;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    sel_d = sel;
    tmr_d = tmr + 16'd1;
    cents_d = dispensed_cents;
    case (state)
      IDLE: if (load) begin
        cnt_d = {dollars, halves, quarters, dimes, nickels};
        cents_d = '0;
        state_d = SELECT;
      end
      SELECT: begin
        tmr_d = '0;
        sel_d = pick;
        state_d = |cnt ? PULSE : DONE;
      end
      PULSE: if (tmr == 16'(PULSE_CYCLES - 1)) begin
        tmr_d = '0;
`ifdef CHANGE_DISPENSER_SENSE_EN
        state_d = WAIT_SENSE;
`else
        cnt_d[sel] = cnt[sel] - 4'd1;
        cents_d = dispensed_cents + val;
        state_d = GAP;
`endif
      end
      WAIT_SENSE: if (coin_sensed) begin
        tmr_d = '0;
        cnt_d[sel] = cnt[sel] - 4'd1;
        cents_d = dispensed_cents + val;
        state_d = GAP;
      end else if (tmr == 16'(SENSE_TIMEOUT - 1)) state_d = FAULT;
      GAP: if (tmr == 16'(GAP_CYCLES - 1)) state_d = SELECT;
      DONE: state_d = IDLE;
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
    // abort discards the remaining coins but keeps the total reached so far
    if (abort && state != IDLE) begin
      state_d = IDLE;
      cnt_d = '0;
      cents_d = dispensed_cents;
    end
    eject_d = state_d == PULSE ? 5'(5'd1 << sel_d) : 5'd0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      sel <= '0;
      tmr <= '0;
      dispensed_cents <= '0;
      eject <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      sel <= sel_d;
      tmr <= tmr_d;
      dispensed_cents <= cents_d;
      eject <= eject_d;
    end
  end
  assign ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == DONE;
`ifdef CHANGE_DISPENSER_SENSE_EN
  assign fault = state == FAULT;
`else
  assign fault = 1'b0;
`endif
endmodule
